instr_loader: RTL

//  Boot-time program loader: the write side of the instruction memory.

---
 rtl/instr_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into
// 32-bit words and writes them into instruction memory from LOAD_BASE.
module instr_loader #(
    parameter logic [31:0] LOAD_BASE       = 32'h3000,
    parameter int          INSTR_MEM_BYTES = 'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS = 32'(INSTR_MEM_BYTES >> 2);
    localparam int          WCW       = $clog2(INSTR_MEM_BYTES >> 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          next;
    logic [1:0]      byte_cnt;
    logic [WCW-1:0]  word_cnt;
    logic [31:0]     length;
    logic [23:0]     shreg;

    logic            take;
    logic            last_byte;
    logic            last_word;
    logic            idle_like;
    logic [31:0]     hdr_len;
    logic [31:0]     word_full;
    logic [31:0]     word_addr;

    assign in_ready  = (state == HDR) || (state == DATA);
    assign busy      = in_ready;
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign idle_like = (state == IDLE) || done || error;

    assign take      = in_valid & in_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign hdr_len   = {length[23:0], in_data};
    assign word_full = {shreg, in_data};
    assign last_word = ({{(32-WCW){1'b0}}, word_cnt} + 32'd1) == length;
    assign word_addr = LOAD_BASE
                     + {{(30-WCW){1'b0}}, word_cnt, 2'b00};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) next = HDR;
            end
            HDR: begin
                if (take && last_byte) begin
                    if (hdr_len == 32'd0)         next = DONE;
                    else if (hdr_len > MAX_WORDS) next = ERR;
                    else                          next = DATA;
                end
            end
            DATA: begin
                if (take && last_byte && last_word) next = DONE;
            end
            default: next = IDLE;
        endcase
    end

    // Byte/word assembly and the one-cycle write strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            length   <= 32'd0;
            shreg    <= 24'd0;
            wr_en    <= 1'b0;
            wr_addr  <= LOAD_BASE;
            wr_data  <= 32'd0;
        end else begin
            wr_en <= 1'b0;
            if (idle_like && start) begin
                byte_cnt <= 2'd0;
                word_cnt <= '0;
                length   <= 32'd0;
                shreg    <= 24'd0;
                wr_addr  <= LOAD_BASE;
            end else if (take && state == HDR) begin
                length   <= hdr_len;
                byte_cnt <= byte_cnt + 2'd1;
            end else if (take && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    wr_en    <= 1'b1;
                    wr_data  <= word_full;
                    wr_addr  <= word_addr;
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    shreg <= {shreg[15:0], in_data};
                end
            end
        end
    end

endmodule
